// File: rtl/hit_judge_if.sv
`default_nettype none
// ============================================================================
//  Module      : hit_judge_if
//  Description : Bundle between the mole generator / player keys and the
//                hit-judging block.
//                master : drives mole_new, mole_hole, key; observes results
//                slave  : hit_judge side, drives ready, hole_led, getpoint,
//                         p, miss
//  Revision    : 1.0  initial release
// ============================================================================
interface hit_judge_if #(
    parameter int N_HOLES = 8
) ();
    localparam int HB = $clog2(N_HOLES);

    logic                mole_new;   // one-cycle mole-appear strobe
    logic [HB-1:0]       mole_hole;  // hole index, valid with mole_new
    logic [N_HOLES-1:0]  key;        // debounced player keys, asynchronous
    logic                ready;      // high only while idle
    logic [N_HOLES-1:0]  hole_led;   // one-hot lit hole during the window
    logic                getpoint;   // award pulse to the score block
    logic [1:0]          p;          // points, nonzero only with getpoint
    logic                miss;       // one-cycle wrong-key / timeout pulse

    modport master (
        output mole_new, mole_hole, key,
        input  ready, hole_led, getpoint, p, miss
    );

    modport slave (
        input  mole_new, mole_hole, key,
        output ready, hole_led, getpoint, p, miss
    );
endinterface
`default_nettype wire

// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
//  Module      : hit_judge
//  Description : Hit-judging front end of the whack-a-mole game. Accepts a
//                mole-appear event, lights the hole, watches the keys for a
//                bounded window and issues a clean multi-cycle getpoint pulse
//                with p stable for its whole duration, followed by one low
//                cycle so the score block sees a fresh rising edge per hit.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - hit_judge_if.slave (mole_new, mole_hole, key in;
//                         ready, hole_led, getpoint, p, miss out)
//  Options     : HIT_SPEED_BONUS_EN - when defined, grade the hit by reaction
//                time (3/2/1 points); otherwise every hit is worth 1.
//  Revision    : 1.0  initial release
// ============================================================================
module hit_judge #(
    parameter int N_HOLES    = 8,
    parameter int WINDOW_CYC = 50_000_000,
    parameter int PULSE_CYC  = 4
) (
    input  wire          clk,
    input  wire          rst_n,
    hit_judge_if.slave   bus
);
    localparam int HB = $clog2(N_HOLES);
    localparam int TW = $clog2(WINDOW_CYC);
    localparam int CW = $clog2(PULSE_CYC + 1);

    localparam logic [TW-1:0] c_T_LAST = TW'(WINDOW_CYC - 1);
    localparam logic [CW-1:0] c_P_LAST = CW'(PULSE_CYC - 1);
    localparam logic [HB:0]   c_NH     = (HB + 1)'(N_HOLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_AWARD  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [HB-1:0]        r_hole, w_hole_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [CW-1:0]        r_pcnt, w_pcnt_nxt;

    logic                 r_ready, w_ready_nxt;
    logic [N_HOLES-1:0]   r_hole_led, w_led_nxt;
    logic                 r_getpoint, w_getpoint_nxt;
    logic [1:0]           r_p, w_p_nxt;
    logic                 r_miss, w_miss_nxt;

    // Key path: two synchronizer stages plus one stage for edge detect.
    logic [N_HOLES-1:0]   r_ks1, r_ks2, r_ks3;
    logic [N_HOLES-1:0]   w_kedge;
    logic [N_HOLES-1:0]   w_hole_oh;
    logic                 w_hole_ok;
    logic [1:0]           w_grade;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ks1 <= '0;
            r_ks2 <= '0;
            r_ks3 <= '0;
        end else begin
            r_ks1 <= bus.key;
            r_ks2 <= r_ks1;
            r_ks3 <= r_ks2;
        end
    end

    assign w_kedge   = r_ks2 & ~r_ks3;
    assign w_hole_ok = ({1'b0, bus.mole_hole} < c_NH);

    always_comb begin
        w_hole_oh = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            w_hole_oh[i] = (r_hole == HB'(i));
        end
    end

`ifdef HIT_SPEED_BONUS_EN
    localparam logic [TW-1:0] c_T_Q1 = TW'(WINDOW_CYC / 4);
    localparam logic [TW-1:0] c_T_Q2 = TW'(WINDOW_CYC / 2);

    // Faster reaction earns more points; graded on the timer in the hit cycle.
    always_comb begin
        w_grade = 2'd1;
        if (r_timer < c_T_Q1) begin
            w_grade = 2'd3;
        end else if (r_timer < c_T_Q2) begin
            w_grade = 2'd2;
        end
    end
`else
    assign w_grade = 2'd1;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hole     <= '0;
            r_timer    <= '0;
            r_pcnt     <= '0;
            r_ready    <= 1'b1;
            r_hole_led <= '0;
            r_getpoint <= 1'b0;
            r_p        <= 2'd0;
            r_miss     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hole     <= w_hole_nxt;
            r_timer    <= w_timer_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_ready    <= w_ready_nxt;
            r_hole_led <= w_led_nxt;
            r_getpoint <= w_getpoint_nxt;
            r_p        <= w_p_nxt;
            r_miss     <= w_miss_nxt;
        end
    end

    // Next-state logic. Outputs are derived from the next state so that every
    // output flop changes together with the state it reflects.
    always_comb begin
        w_state_nxt = r_state;
        w_hole_nxt  = r_hole;
        w_timer_nxt = r_timer;
        w_pcnt_nxt  = r_pcnt;
        w_p_nxt     = r_p;
        w_miss_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.mole_new && w_hole_ok) begin
                    w_state_nxt = S_WINDOW;
                    w_hole_nxt  = bus.mole_hole;
                    w_timer_nxt = '0;
                end
            end
            S_WINDOW: begin
                w_timer_nxt = r_timer + 1'b1;
                // Key edges are checked before the timeout so that a hit in
                // the last window cycle still counts.
                if (w_kedge == w_hole_oh) begin
                    w_state_nxt = S_AWARD;
                    w_pcnt_nxt  = '0;
                    w_p_nxt     = w_grade;
                end else if (w_kedge != '0) begin
                    w_state_nxt = S_GAP;
                    w_miss_nxt  = 1'b1;
                end else if (r_timer == c_T_LAST) begin
                    w_state_nxt = S_GAP;
                    w_miss_nxt  = 1'b1;
                end
            end
            S_AWARD: begin
                if (r_pcnt == c_P_LAST) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_pcnt_nxt = r_pcnt + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // p is only allowed to be nonzero while getpoint is high.
        if (w_state_nxt != S_AWARD) begin
            w_p_nxt = 2'd0;
        end
    end

    always_comb begin
        w_ready_nxt    = (w_state_nxt == S_IDLE);
        w_getpoint_nxt = (w_state_nxt == S_AWARD);
        w_led_nxt      = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            w_led_nxt[i] = (w_state_nxt == S_WINDOW) && (w_hole_nxt == HB'(i));
        end
    end

    assign bus.ready    = r_ready;
    assign bus.hole_led = r_hole_led;
    assign bus.getpoint = r_getpoint;
    assign bus.p        = r_p;
    assign bus.miss     = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hit_judge
//  Description : Directed self-checking bench for hit_judge with
//                N_HOLES=8, WINDOW_CYC=40, PULSE_CYC=4. Follows the
//                HIT_SPEED_BONUS_EN define for the expected grades.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hit_judge;
    localparam int N_HOLES    = 8;
    localparam int WINDOW_CYC = 40;
    localparam int PULSE_CYC  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_score = 0;
    int   score;
    logic prev_gp;

    hit_judge_if #(.N_HOLES(N_HOLES)) bus ();

    hit_judge #(
        .N_HOLES   (N_HOLES),
        .WINDOW_CYC(WINDOW_CYC),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Score consumer: adds p on every rising edge of getpoint.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score   <= 0;
            prev_gp <= 1'b0;
        end else begin
            prev_gp <= bus.getpoint;
            if (bus.getpoint && !prev_gp) score <= score + int'(bus.p);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived grades: t<10 -> 3, t<20 -> 2, else 1 with the bonus on.
    function automatic logic [1:0] grade(input int t);
`ifdef HIT_SPEED_BONUS_EN
        if (t < 10) return 2'd3;
        if (t < 20) return 2'd2;
`endif
        return 2'd1;
    endfunction

    // Launch a mole on 'hole', raise 'kmask' so its edge is seen at timer=t
    // (t >= 2), and check either a full award or a miss.
    task automatic run_mole(input string tag, input int hole, input logic [7:0] kmask,
                            input int t, input bit exp_hit);
        logic [7:0] led;
        logic [1:0] ep;
        led = 8'd1 << hole;
        ep  = grade(t);
        bus.mole_new  = 1'b1;
        bus.mole_hole = 3'(hole);
        tick();
        bus.mole_new = 1'b0;
        check({tag, "_ready_lo"}, 32'(bus.ready), 32'd0);
        check({tag, "_led"}, 32'(bus.hole_led), 32'(led));
        repeat (t - 2) tick();
        bus.key = kmask;
        repeat (3) tick();
        if (exp_hit) begin
            for (int i = 0; i < PULSE_CYC; i++) begin
                check({tag, "_gp"}, 32'(bus.getpoint), 32'd1);
                check({tag, "_p"}, 32'(bus.p), 32'(ep));
                check({tag, "_nomiss"}, 32'(bus.miss), 32'd0);
                tick();
            end
            exp_score += int'(ep);
            check({tag, "_gap_gp"}, 32'(bus.getpoint), 32'd0);
            check({tag, "_gap_p"}, 32'(bus.p), 32'd0);
        end else begin
            check({tag, "_miss"}, 32'(bus.miss), 32'd1);
            check({tag, "_miss_gp"}, 32'(bus.getpoint), 32'd0);
        end
        tick();
        check({tag, "_ready_hi"}, 32'(bus.ready), 32'd1);
        check({tag, "_miss_lo"}, 32'(bus.miss), 32'd0);
        check({tag, "_gp_lo"}, 32'(bus.getpoint), 32'd0);
        bus.key = '0;
        repeat (3) tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mole_new  = 1'b0;
        bus.mole_hole = '0;
        bus.key       = '0;

        // Reset and idle.
        #12;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_gp", 32'(bus.getpoint), 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_led", 32'(bus.hole_led), 32'd0);
        check("idle_gp", 32'(bus.getpoint), 32'd0);
        check("idle_p", 32'(bus.p), 32'd0);
        check("idle_miss", 32'(bus.miss), 32'd0);

        // Out-of-range hole cannot occur with 3-bit index and 8 holes; instead
        // confirm a key edge in IDLE is ignored.
        bus.key = 8'h10;
        repeat (4) tick();
        check("idle_key_ready", 32'(bus.ready), 32'd1);
        check("idle_key_miss", 32'(bus.miss), 32'd0);
        bus.key = '0;
        repeat (3) tick();

        // Hits at various reaction times, back to back.
        run_mole("h5_t3",  5, 8'h20, 3,  1'b1);
        run_mole("h2_t15", 2, 8'h04, 15, 1'b1);
        run_mole("h2_t30", 2, 8'h04, 30, 1'b1);
        run_mole("h7_t9",  7, 8'h80, 9,  1'b1);
        run_mole("h7_t10", 7, 8'h80, 10, 1'b1);
        run_mole("h1_t19", 1, 8'h02, 19, 1'b1);
        run_mole("h1_t20", 1, 8'h02, 20, 1'b1);

        // Wrong key and double key.
        run_mole("wrong", 2, 8'h10, 6, 1'b0);
        run_mole("double", 2, 8'h0C, 6, 1'b0);

        // Timeout after 40 window cycles.
        bus.mole_new  = 1'b1;
        bus.mole_hole = 3'd0;
        tick();
        bus.mole_new = 1'b0;
        repeat (39) tick();
        check("to_t39_miss", 32'(bus.miss), 32'd0);
        check("to_t39_led", 32'(bus.hole_led), 32'd1);
        tick();
        check("to_miss", 32'(bus.miss), 32'd1);
        check("to_led_off", 32'(bus.hole_led), 32'd0);
        check("to_gp", 32'(bus.getpoint), 32'd0);
        tick();
        check("to_ready", 32'(bus.ready), 32'd1);
        repeat (2) tick();

        // Correct edge in the last window cycle wins over timeout.
        run_mole("h0_t39", 0, 8'h01, 39, 1'b1);

        // mole_new during AWARD is dropped.
        bus.mole_new  = 1'b1;
        bus.mole_hole = 3'd1;
        tick();
        bus.mole_new = 1'b0;
        repeat (3) tick();
        bus.key = 8'h02;
        repeat (3) tick();
        check("drop_gp1", 32'(bus.getpoint), 32'd1);
        exp_score += int'(grade(5));
        bus.mole_new  = 1'b1;
        bus.mole_hole = 3'd3;
        tick();
        bus.mole_new = 1'b0;
        check("drop_gp2", 32'(bus.getpoint), 32'd1);
        check("drop_led", 32'(bus.hole_led), 32'd0);
        repeat (3) tick();
        check("drop_gap", 32'(bus.getpoint), 32'd0);
        tick();
        check("drop_ready", 32'(bus.ready), 32'd1);
        tick();
        check("drop_still_idle", 32'(bus.ready), 32'd1);
        check("drop_led_idle", 32'(bus.hole_led), 32'd0);
        bus.key = '0;
        repeat (3) tick();

        // Score consumer total.
        check("score_total", 32'(score), 32'(exp_score));

        // Reset in the middle of an award; key held through reset.
        bus.mole_new  = 1'b1;
        bus.mole_hole = 3'd6;
        tick();
        bus.mole_new = 1'b0;
        repeat (2) tick();
        bus.key = 8'h40;
        repeat (3) tick();
        check("rstmid_gp_before", 32'(bus.getpoint), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_gp", 32'(bus.getpoint), 32'd0);
        check("rstmid_p", 32'(bus.p), 32'd0);
        check("rstmid_ready", 32'(bus.ready), 32'd1);
        check("rstmid_led", 32'(bus.hole_led), 32'd0);
        check("rstmid_miss", 32'(bus.miss), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("held_key_ready", 32'(bus.ready), 32'd1);
        check("held_key_miss", 32'(bus.miss), 32'd0);
        check("held_key_gp", 32'(bus.getpoint), 32'd0);
        bus.key = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hit_judge.md
# hit_judge

Hit-judging front end of the whack-a-mole game: accepts a mole-appear event from the mole generator, lights the hole, watches the player keys for a bounded window, and awards points. It is the producer side of the score interface. It drives `getpoint` as a clean multi-cycle pulse with `p` stable for its whole duration, so the score accumulator's rising-edge detector adds exactly `p` once per hit.

## Interface
- `N_HOLES`, 8: number of holes/keys.
- `WINDOW_CYC`, 50_000_000: hit window length in clk cycles (1 s at 50 MHz); must be ≥ 8.
- `PULSE_CYC`, 4: `getpoint` high time in cycles; must be ≥ 1.
- `HB` (localparam) = `$clog2(N_HOLES)`.
- `TW` (localparam) = `$clog2(WINDOW_CYC)`.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mole_new` in 1: one-cycle mole-appear strobe.
- `mole_hole` in HB: hole index, valid with `mole_new`.
- `key` in N_HOLES: player keys; asynchronous, already debounced, active-high.
- `ready` out 1: high only in IDLE.
- `hole_led` out N_HOLES: one-hot active hole during WINDOW, else 0.
- `getpoint` out 1: award pulse to the score block.
- `p` out 2: points for this award; nonzero only while `getpoint`=1.
- `miss` out 1: one-cycle pulse on wrong key or timeout.

## Operation
- Key path per bit: two-flop synchronizer, then a third flop for rising-edge detect. `kedge[i] = s2[i] & ~s3[i]`.
- FSM states: IDLE, WINDOW, AWARD, GAP. All state and output flops are registered.
- **IDLE**
  - `mole_new`=1 with `mole_hole` < N_HOLES: latch hole, clear timer, go to WINDOW.
  - Out-of-range hole: ignored.
  - All key edges are ignored.
- **WINDOW**
  - Timer increments each cycle, starting at 0 in the first WINDOW cycle.
  - Hit: `kedge` == one-hot(hole). Latch grade into `p`, go to AWARD.
  - Any other nonzero `kedge` (wrong key, or correct key plus any other key in the same cycle): pulse `miss`, go to GAP.
  - Timeout: `timer == WINDOW_CYC-1` with `kedge` == 0: pulse `miss`, go to GAP.
  - A key edge in the last window cycle takes priority over timeout.
- **AWARD**
  - `getpoint`=1 and `p` held constant for exactly PULSE_CYC cycles, then go to GAP.
- **GAP**
  - Exactly 1 cycle with `getpoint`=0 and `p`=0, then go to IDLE.
  - Guarantees a low cycle between awards, so the consumer sees a fresh rising edge.
- `mole_new` outside IDLE: dropped. No queueing.
- Grade uses the timer value t in the hit cycle (see Configuration).

## Timing
- Reset values: state IDLE, `ready`=1, `hole_led`=0, `getpoint`=0, `p`=0, `miss`=0. Synchronizer flops and timer are cleared to 0.
- `mole_new` sampled at edge n: `hole_led` and WINDOW active from cycle n+1; `ready` low from n+1.
- Key rising at the pins before edge k: `kedge` high in cycle k+2. State transition occurs at the end of that cycle, so `getpoint`/`miss` go high in cycle k+3.
- `p` and `getpoint` change in the same cycle. `p` is never nonzero while `getpoint`=0.
- Minimum mole-to-mole period: 1 + (window time) + PULSE_CYC + 1 cycles.
- A key held through reset produces an edge after reset. If the FSM is in IDLE it is ignored.
- Reset mid-AWARD: `getpoint` drops asynchronously. Partial pulses are acceptable; the consumer is reset by the same `rst_n`.

## Configuration
- `HIT_SPEED_BONUS_EN` defined:
  - t < WINDOW_CYC/4 → `p`=3
  - t < WINDOW_CYC/2 → `p`=2
  - otherwise → `p`=1
- Not defined: every hit gives `p`=1, and the grading comparators are not built.

## Test plan
All scenarios use N_HOLES=8, WINDOW_CYC=40, PULSE_CYC=4.

- Reset, then idle 10 cycles → `ready`=1, all other outputs 0.
- `mole_new` with hole 5, key[5] edge detected at t=3 → `getpoint` high for 4 cycles with `p`=3 (bonus on) or 1 (bonus off); then 1 low cycle, then `ready`=1.
- Hole 2, hit at t=15 → `p`=2. Hit at t=30 → `p`=1 (bonus on).
- Hole 2, key[4] edge → `miss` for 1 cycle, `getpoint` never high. Separately, key[2] and key[3] edges in the same cycle → `miss`.
- Hole 0 with no key → `miss` when timer = 39, i.e. 40 WINDOW cycles. A correct edge at t=39 → award, no `miss`.
- Back-to-back awards driven into a score model → total = sum of `p`. `mole_new` during AWARD is dropped. Asserting `rst_n`=0 mid-AWARD → all outputs 0 immediately.
